// File: rtl/decoder_nto1hot_seq.sv
// decoder_nto1hot_seq: registered binary-to-one-hot decoder with HOLD and SCAN modes.
// Optional sticky range-error flag enabled by defining DECODER_RANGE_CHECK_EN.
`default_nettype none

module decoder_nto1hot_seq #(
    parameter int SEL_W   = 2,
    parameter int NUM_OUT = 4,
    parameter int DWELL   = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en_i,
    input  logic               mode_i,
    input  logic               load_i,
    input  logic [SEL_W-1:0]   sel_i,
    output logic               in_ready_o,
    output logic [NUM_OUT-1:0] decoded_o,
    output logic [SEL_W-1:0]   active_idx_o,
    output logic               wrap_o,
    input  logic               err_clr_i,
    output logic               err_o
);

    localparam int                 CNT_W       = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST    = CNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0]   IDX_LAST    = SEL_W'(NUM_OUT - 1);
    localparam logic [SEL_W:0]     NUM_OUT_EXT = (SEL_W + 1)'(NUM_OUT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_SCAN = 2'd2
    } state_t;

    state_t             state_q;
    logic [NUM_OUT-1:0] decoded_q;
    logic [SEL_W-1:0]   active_idx_q;
    logic [CNT_W-1:0]   dwell_q;
    logic               wrap_q;

    logic               sel_in_range;
    logic               scan_at_last;
    logic [SEL_W-1:0]   scan_idx_d;
    logic [NUM_OUT-1:0] load_onehot_d;
    logic [NUM_OUT-1:0] scan_onehot_d;

    assign sel_in_range  = ({1'b0, sel_i} < NUM_OUT_EXT);
    assign scan_at_last  = (active_idx_q == IDX_LAST);
    assign scan_idx_d    = scan_at_last ? '0 : active_idx_q + SEL_W'(1);
    assign load_onehot_d = NUM_OUT'(1) << sel_i;
    assign scan_onehot_d = NUM_OUT'(1) << scan_idx_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            decoded_q    <= '0;
            active_idx_q <= '0;
            dwell_q      <= '0;
            wrap_q       <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            if (!en_i) begin
                state_q   <= S_IDLE;
                decoded_q <= '0;
            end else if (load_i) begin
                // A load always wins over a same-edge dwell advance, so no wrap here.
                if (sel_in_range) begin
                    decoded_q    <= load_onehot_d;
                    active_idx_q <= sel_i;
                    dwell_q      <= '0;
                    state_q      <= mode_i ? S_SCAN : S_HOLD;
                end else begin
                    decoded_q <= '0;
                    state_q   <= S_IDLE;
                end
            end else begin
                case (state_q)
                    S_SCAN: begin
                        if (dwell_q == CNT_LAST) begin
                            dwell_q      <= '0;
                            active_idx_q <= scan_idx_d;
                            decoded_q    <= scan_onehot_d;
                            wrap_q       <= scan_at_last;
                        end else begin
                            dwell_q <= dwell_q + CNT_W'(1);
                        end
                    end
                    S_IDLE: begin
                        decoded_q <= '0;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

`ifdef DECODER_RANGE_CHECK_EN
    logic err_q;

    // Set has priority over clear when both happen on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (en_i && load_i && !sel_in_range) begin
            err_q <= 1'b1;
        end else if (en_i && err_clr_i) begin
            err_q <= 1'b0;
        end
    end

    assign err_o = err_q;
`else
    logic unused_err_clr;

    assign unused_err_clr = err_clr_i;
    assign err_o          = 1'b0;
`endif

    assign in_ready_o   = en_i;
    assign decoded_o    = decoded_q;
    assign active_idx_o = active_idx_q;
    assign wrap_o       = wrap_q;

endmodule

`default_nettype wire

// File: doc/decoder_nto1hot_seq.md
# decoder_nto1hot_seq

Parametrised, registered binary-to-one-hot decoder; next generation of the 2-to-4 select decoder used in the mux datapaths. Adds a configurable output count, a load handshake, a hold mode, and an auto-scan mode that walks the active line at a programmable dwell rate. Drives the mux select lines, or strobes a bank of channels round-robin, from one clocked block.

## Interface
- `SEL_W`, default 2: select width.
- `NUM_OUT`, default 4: number of one-hot lines; legal range 2..2**SEL_W.
- `DWELL`, default 1: cycles each line stays active in SCAN; must be ≥1.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst` input, 1 bit: **asynchronous, active-high reset**.
- `en` input, 1 bit: block enable.
- `mode` input, 1 bit: applied at load; 0 = HOLD, 1 = SCAN.
- `load` input, 1 bit: load request.
- `sel` input, SEL_W bits: line index to load.
- `in_ready` output, 1 bit: load accepted this edge when `load & in_ready`; equals `en`, combinational.
- `decoded` output, NUM_OUT bits: registered one-hot, or all zero.
- `active_idx` output, SEL_W bits: registered index of the active line.
- `wrap` output, 1 bit: registered one-cycle pulse on scan wrap.
- `err_clr` input, 1 bit: clears `err`.
- `err` output, 1 bit: sticky out-of-range flag; see Configuration.

## Operation
- States: IDLE, HOLD, SCAN.
- Reset values: state IDLE, `decoded`=0, `active_idx`=0, dwell counter 0, `wrap`=0, `err`=0.
- `en`=0 has priority below `rst` and above everything else:
  - next edge → IDLE, `decoded`=0.
  - `active_idx` is held.
  - `wrap`=0.
- Accepted load with `sel`<NUM_OUT, from any state:
  - `decoded` ← one-hot(`sel`), `active_idx` ← `sel`, dwell counter ← 0.
  - state ← HOLD if `mode`=0, SCAN if `mode`=1.
- Accepted load with `sel`≥NUM_OUT, from any state:
  - state ← IDLE, `decoded` ← 0, `active_idx` held.
  - `err` ← 1 when the macro is defined.
- IDLE with no load: outputs held, `decoded`=0.
- HOLD with no load: all outputs held. Changes to `mode` are ignored until the next load.
- SCAN with no load:
  - Dwell counter increments each cycle.
  - When it equals DWELL-1: counter ← 0 and `active_idx` ← (`active_idx`+1) mod NUM_OUT. `decoded` follows `active_idx`.
  - Index wraps NUM_OUT-1 → 0 → `wrap`=1 for exactly that cycle; otherwise `wrap`=0.
- Load in SCAN takes priority over a dwell advance on the same edge. The `wrap` pulse is suppressed on that edge.
- Invariant: `decoded` has either exactly one bit set, at position `active_idx`, or is all zero.
- `err_clr` clears `err` on the next edge. If a new out-of-range load arrives on the same edge, set wins.

## Timing
- Load → `decoded`/`active_idx` valid: 1 cycle, registered.
- No combinational path from `sel` to `decoded`.
- SCAN period: NUM_OUT×DWELL cycles. Each line stays high for exactly DWELL consecutive cycles.
- DWELL=1: line advances every cycle, starting the cycle after load.
- `wrap` asserts in the same cycle `decoded` shows line 0 after a wrap.
- `rst` asserted mid-scan: outputs go to reset values immediately, asynchronously. First load is accepted on the first edge after `rst` deasserts.
- `en` deasserted mid-scan: `decoded`=0 one edge later. Scan resumes only via a new load.

## Configuration
- `DECODER_RANGE_CHECK_EN` defined:
  - Out-of-range loads set sticky `err`.
  - `err_clr` is functional.
- Macro undefined:
  - `err` tied to 0 and `err_clr` ignored.
  - Out-of-range loads still force IDLE with `decoded`=0.

## Test plan
- Reset: assert `rst` mid-SCAN, asynchronously and off-edge → `decoded`=0, `active_idx`=0, `wrap`=0, `err`=0 before the next edge.
- HOLD, defaults: load `sel`=2, `mode`=0 → next cycle `decoded`=4'b0100, `active_idx`=2. Held for 20 cycles while `mode` toggles.
- SCAN, NUM_OUT=4, DWELL=3, load `sel`=1:
  - `decoded` sequence: 0010×3, 0100×3, 1000×3, 0001×3.
  - `wrap`=1 only on the first 0001 cycle.
  - Period 12 cycles.
- Priority: SCAN, DWELL=1, load `sel`=0 on the edge where the index would wrap 3→0 → `decoded`=0001, `wrap`=0, dwell restarted.
- Range check, NUM_OUT=5, SEL_W=3, macro on:
  - Load `sel`=6 → `decoded`=0, state IDLE, `err`=1.
  - `err` stays 1 after a valid load; `err_clr` clears it.
  - Same stimulus with macro off → `err`=0 throughout.
- Enable: drop `en` for 1 cycle mid-SCAN → `in_ready`=0 that cycle, `decoded`=0 next edge, stays 0 until a new load.
